// File: rtl/a_reg_wr_arb_pkg.sv
// Shared constants and helpers for register-bank users and the write arbiter.
package a_reg_wr_arb_pkg;

   localparam int unsigned A_REG_SIZE = 8;
   localparam int unsigned A_REG_NREG = 8;

   // Ceiling log2, minimum 0; used for address and pointer widths.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/a_reg_wr_arb_lat_reg.sv
// Single enabled register of the configuration bank.
module a_lat_reg #(
   parameter int unsigned      SIZE    = 8,
   parameter logic [SIZE-1:0]  RST_VAL = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena_i,
   input  logic [SIZE-1:0] d_i,
   output logic [SIZE-1:0] q_o
);

   logic [SIZE-1:0] q_q;

   // Load on enable, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     q_q <= RST_VAL;
      else if (ena_i) q_q <= d_i;
   end

   assign q_o = q_q;

endmodule

// File: rtl/a_reg_wr_arb_rr_arb.sv
// Round-robin picker: first eligible requester at or after ptr_i, wrapping.
module a_rr_arb
   import a_reg_wr_arb_pkg::*;
#(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned PW   = clog2(NREQ)
) (
   input  logic [NREQ-1:0] elig_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] win_o,
   output logic            valid_o
);

   // Scan from the pointer upward; the first eligible bit wins.
   always_comb begin : pick
      int unsigned idx;
      idx     = 0;
      win_o   = '0;
      valid_o = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(ptr_i) + k) % NREQ;
         if (!valid_o && elig_i[idx]) begin
            win_o[idx] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/a_reg_wr_arb.sv
// Shared write controller: round-robin arbitration, one registered write per
// cycle into an NREG x SIZE bank, combinational read port.
module a_reg_wr_arb
   import a_reg_wr_arb_pkg::*;
#(
   parameter  int unsigned     NREQ    = 4,
   parameter  int unsigned     NREG    = A_REG_NREG,
   parameter  int unsigned     SIZE    = A_REG_SIZE,
   parameter  logic [SIZE-1:0] RST_VAL = '0,
   localparam int unsigned     AW      = clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*AW-1:0]   waddr,
   input  logic [NREQ*SIZE-1:0] wdat,
   input  logic [NREG-1:0]      lock,
   output logic [NREQ-1:0]      gnt,
   output logic                 err,
   input  logic [AW-1:0]        raddr,
   output logic [SIZE-1:0]      rdat
);

   localparam int unsigned PW = clog2(NREQ);

   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            err_q, err_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [SIZE-1:0] wr_dat_q, wr_dat_d;
   logic            wr_ok_q, wr_ok_d;
   logic [NREQ-1:0] elig, win;
   logic            win_vld;
   logic            wen;
   logic [NREG-1:0] ena;
   logic [SIZE-1:0] bank [NREG];

   // A requester in its grant cycle is masked so a held req is not re-granted.
   assign elig = req & ~gnt_q;

   a_rr_arb #(.NREQ(NREQ)) u_arb (
      .elig_i  (elig),
      .ptr_i   (ptr_q),
      .win_o   (win),
      .valid_o (win_vld)
   );

   // Capture winner's address/data and decide write-vs-drop at the decision edge.
   always_comb begin : decide
      logic [AW-1:0] a;
      a         = '0;
      gnt_d     = win;
      ptr_d     = ptr_q;
      err_d     = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_dat_d  = wr_dat_q;
      wr_ok_d   = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win[i]) begin
            a         = waddr[i*AW +: AW];
            wr_addr_d = a;
            wr_dat_d  = wdat[i*SIZE +: SIZE];
            ptr_d     = (i == NREQ - 1) ? '0 : PW'(i + 1);
         end
      end
      if (win_vld) begin
         // Out-of-range addresses never match, leaving wr_ok_d low.
         for (int unsigned j = 0; j < NREG; j++) begin
            if (a == AW'(j)) wr_ok_d = ~lock[j];
         end
         err_d = ~wr_ok_d;
      end
   end

   // Arbitration state, grant/err pulses and the pending write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         gnt_q     <= '0;
         err_q     <= 1'b0;
         wr_addr_q <= '0;
         wr_dat_q  <= '0;
         wr_ok_q   <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         err_q     <= err_d;
         wr_addr_q <= wr_addr_d;
         wr_dat_q  <= wr_dat_d;
         wr_ok_q   <= wr_ok_d;
      end
   end

   assign wen = (|gnt_q) & wr_ok_q;

   for (genvar g = 0; g < NREG; g++) begin : g_reg
      assign ena[g] = wen & (wr_addr_q == AW'(g));
      a_lat_reg #(.SIZE(SIZE), .RST_VAL(RST_VAL)) u_reg (
         .clk   (clk),
         .rst_n (rst_n),
         .ena_i (ena[g]),
         .d_i   (wr_dat_q),
         .q_o   (bank[g])
      );
   end

   // Read mux; unpopulated addresses return the reset value.
   always_comb begin
      rdat = RST_VAL;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (raddr == AW'(i)) rdat = bank[i];
      end
   end

   assign gnt = gnt_q;
   assign err = err_q;

endmodule

// File: doc/a_reg_wr_arb.md
# a_reg_wr_arb

Shared write controller for a bank of enabled registers: arbitrates write requests from NREQ requesters with round-robin fairness, issues one registered write per cycle into an NREG x SIZE register bank, and exposes an asynchronous read port. It sits between the configuration masters (CPU bridge, DMA descriptor loader, debug port) and the block-level configuration registers they share.

## Interface
- NREQ, 4, number of requesters (2..8)
- NREG, 8, number of registers in the bank (2..16, not necessarily a power of two)
- SIZE, 8, register data width
- AW, clog2(NREG), register address width (derived, not overridden)
- RST_VAL, {SIZE{1'b0}}, reset value of every register
- clk  in  1  clock; all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  write request per requester, level
- waddr  in  NREQ*AW  per-requester target address, slice i = requester i
- wdat  in  NREQ*SIZE  per-requester write data, slice i = requester i
- lock  in  NREG  write-protect per register, sampled at decision edge
- gnt  out  NREQ  one-hot grant pulse, registered
- err  out  1  pulse, granted write was dropped (locked or address >= NREG)
- raddr  in  AW  read address
- rdat  out  SIZE  combinational read of register raddr; RST_VAL if raddr >= NREG

## Operation
- Eligible set at each edge: req & ~gnt (a requester granted in the current cycle is not eligible at the edge ending that cycle).
- Round-robin: search eligible set starting at pointer ptr, ascending, wrapping NREQ-1 -> 0; first hit wins. On a win, ptr <= winner+1 (mod NREQ); with no win, ptr holds.
- At the decision edge the winner's waddr/wdat slices and lock[waddr] are captured into wr_addr_r/wr_dat_r; gnt[winner] <= 1, all other gnt bits 0.
- In the grant cycle: write enable = gnt != 0 and address < NREG and lock not set; else err = 1 for that cycle, bank unchanged.
- Register i loads wr_dat_r at the edge ending the grant cycle when enabled and wr_addr_r == i.
- Requester protocol: hold req, waddr, wdat stable until gnt seen; may drop or change them in the cycle after gnt. Dropping req before grant withdraws the request without effect.
- Same address from different requesters in consecutive grants: later grant wins (last write).
- lock changes after the decision edge do not affect the captured decision.

## Timing
- Reset values: gnt = 0, err = 0, ptr = 0, all registers = RST_VAL, no write pending.
- Latency: req high at edge E -> gnt high cycle E..E+1 -> rdat shows new value from edge E+1 onward (1 cycle after gnt).
- Throughput: one write per cycle across requesters; one write per 2 cycles per requester.
- Reset mid-operation: asserting rst_n low clears gnt, err and ptr immediately (async); a write in its grant cycle is lost; registers return to RST_VAL.
- rdat combinational from raddr and bank; no pipeline.

## Structure
- Shared package/header: clog2 function and the default SIZE/NREG constants used by register-bank users; no typedefs.
- Sub-module a_rr_arb: NREQ-wide round-robin picker (eligible vector + ptr in, one-hot winner + valid out), reusable elsewhere.
- Register bank: NREG instances of a_lat_reg (SIZE, RST_VAL), ena driven by decoded write enable.
- Top holds ptr, capture registers, gnt/err flops, read mux.

## Test plan
- Reset: after rst_n release with raddr sweeping 0..7 -> rdat = 8'h00, gnt = 0, err = 0.
- Single write: req[2]=1, waddr=3, wdat=8'hA5 at edge 1 -> gnt = 4'b0100 in cycle 1, rdat(3) = 8'hA5 from edge 2; no second grant to requester 2 if req dropped after gnt.
- Fairness: all four req held with distinct addresses -> grants 0,1,2,3 on consecutive cycles, then 0 again after requester 0 re-requests; ptr wraps 3 -> 0.
- Lock/range: lock[5]=1, requester 1 writes 5 with 8'h3C -> gnt[1] pulse, err = 1 same cycle, rdat(5) unchanged; NREG=6 and waddr=7 -> err, no register changed.
- Collision: requesters 0 and 3 both target address 4 with 8'h11, 8'h22, ptr = 0 -> final rdat(4) = 8'h22.
- Async reset during grant cycle of 8'hFF to address 1 -> gnt drops immediately, rdat(1) = 8'h00 after release, ptr = 0 (next arbitration starts at requester 0).
